// File: rtl/blocpu_imem_loader.sv
// Instruction memory loader for blocpu: host write port, core fetch port,
// and the LOAD/START/RUN/HALTED run-control sequencer.
module blocpu_imem_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 12
) (
  input  logic                   in_clock,
  input  logic                   in_reset_n,
  input  logic [INSTR_WIDTH-1:0] in_instruction,
  input  logic [15:0]            in_instruction_address,
  input  logic                   in_instruction_write,
  input  logic                   in_running,
  input  logic                   in_halt,
  input  logic [15:0]            in_fetch_address,
  output logic [INSTR_WIDTH-1:0] out_fetch_instruction,
  output logic                   out_fetch_valid,
  output logic                   out_reset,
  output logic                   out_running,
  output logic [15:0]            out_write_count,
  output logic                   out_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_LOAD,
    S_START,
    S_RUN,
    S_HALTED
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_wr_s1;
  logic r_wr_s2;
  logic r_wr_d;
  logic r_run_s1;
  logic r_run_s2;

  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]       r_valid;
  logic [INSTR_WIDTH-1:0] r_fdata;
  logic                   r_fvalid;
  logic [15:0]            r_count;
  logic                   r_err;

  logic                  w_wr_edge;
  logic                  w_wr_range;
  logic                  w_wr_ok;
  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic                  w_f_range;
  logic [ADDR_WIDTH-1:0] w_f_idx;

  assign w_wr_edge  = r_wr_s2 & ~r_wr_d;
  assign w_wr_range = (in_instruction_address[15:ADDR_WIDTH] == '0);
  assign w_wr_idx   = in_instruction_address[ADDR_WIDTH-1:0];
  assign w_wr_ok    = w_wr_edge && w_wr_range && (r_state == S_LOAD);
  assign w_f_range  = (in_fetch_address[15:ADDR_WIDTH] == '0);
  assign w_f_idx    = in_fetch_address[ADDR_WIDTH-1:0];

  // Both host-side levels are asynchronous to in_clock.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_wr_s1  <= 1'b0;
      r_wr_s2  <= 1'b0;
      r_wr_d   <= 1'b0;
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
    end else begin
      r_wr_s1  <= in_instruction_write;
      r_wr_s2  <= r_wr_s1;
      r_wr_d   <= r_wr_s2;
      r_run_s1 <= in_running;
      r_run_s2 <= r_run_s1;
    end
  end

  always_ff @(posedge in_clock) begin
    if (w_wr_ok) begin
      r_mem[w_wr_idx] <= in_instruction;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_valid <= '0;
    end else if (w_wr_ok) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Reads see the pre-write contents on a same-cycle collision.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_fdata  <= '1;
      r_fvalid <= 1'b0;
    end else if (w_f_range && r_valid[w_f_idx]) begin
      r_fdata  <= r_mem[w_f_idx];
      r_fvalid <= 1'b1;
    end else begin
      r_fdata  <= '1;
      r_fvalid <= 1'b0;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_wr_edge) begin
      if (w_wr_ok) begin
        if (r_count != 16'hFFFF) begin
          r_count <= r_count + 16'd1;
        end
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort (run request dropped) takes priority over halt in RUN.
  always_comb begin
    w_next      = r_state;
    out_reset   = 1'b1;
    out_running = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        if (r_run_s2) begin
          w_next = S_START;
        end
      end
      S_START: begin
        out_reset = 1'b0;
        w_next    = S_RUN;
      end
      S_RUN: begin
        out_reset   = 1'b0;
        out_running = 1'b1;
        if (!r_run_s2) begin
          w_next = S_LOAD;
        end else if (in_halt) begin
          w_next = S_HALTED;
        end
      end
      S_HALTED: begin
        out_reset = 1'b0;
        if (!r_run_s2) begin
          w_next = S_LOAD;
        end
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  assign out_fetch_instruction = r_fdata;
  assign out_fetch_valid       = r_fvalid;
  assign out_write_count       = r_count;
  assign out_error             = r_err;

endmodule

// File: tb/tb_blocpu_imem_loader.sv
// Scoreboard bench for blocpu_imem_loader: stimulus pushes timed
// expectations from a reference model, a monitor compares them.
module tb_blocpu_imem_loader;

  localparam int AW    = 8;
  localparam int IW    = 12;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] wd = '0;
  logic [15:0]   wa = '0;
  logic          wr = 1'b0;
  logic          run = 1'b0;
  logic          halt = 1'b0;
  logic [15:0]   fa = '0;
  logic [IW-1:0] fdata;
  logic          fvalid;
  logic          creset;
  logic          crun;
  logic [15:0]   cnt;
  logic          err;

  blocpu_imem_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .in_clock              (clk),
    .in_reset_n            (rst_n),
    .in_instruction        (wd),
    .in_instruction_address(wa),
    .in_instruction_write  (wr),
    .in_running            (run),
    .in_halt               (halt),
    .in_fetch_address      (fa),
    .out_fetch_instruction (fdata),
    .out_fetch_valid       (fvalid),
    .out_reset             (creset),
    .out_running           (crun),
    .out_write_count       (cnt),
    .out_error             (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [IW-1:0] mem_m [DEPTH];
  bit            val_m [DEPTH];
  int            count_m = 0;
  bit            err_m = 0;
  bit            load_m = 1;

  function automatic void push(int kind, int due, logic [31:0] e, string n);
    exp_t t;
    t.due  = due;
    t.kind = kind;
    t.exp  = e;
    t.name = n;
    q.push_back(t);
  endfunction

  function automatic logic [31:0] actual(int kind);
    case (kind)
      0:       return 32'(fdata);
      1:       return 32'(fvalid);
      2:       return 32'(creset);
      3:       return 32'(crun);
      4:       return 32'(cnt);
      default: return 32'(err);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        logic [31:0] a;
        a = actual(q[i].kind);
        checks++;
        if (a !== q[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d: got %0h expected %0h",
                   q[i].name, cyc, a, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fetch_exp(input logic [15:0] a, input int due, input string n);
    bit            v;
    logic [IW-1:0] d;
    v = 0;
    d = '1;
    if (a < DEPTH) begin
      if (val_m[a[AW-1:0]]) begin
        v = 1;
        d = mem_m[a[AW-1:0]];
      end
    end
    push(0, due, 32'(d), n);
    push(1, due, 32'(v), n);
  endtask

  task automatic do_fetch(input logic [15:0] a);
    step();
    fa = a;
    fetch_exp(a, cyc + 1, "fetch");
  endtask

  task automatic do_write(input logic [15:0] a, input logic [IW-1:0] d);
    int c;
    bit acc;
    int nc;
    step();
    c   = cyc;
    wa  = a;
    wd  = d;
    wr  = 1'b1;
    acc = load_m && (a < DEPTH);
    nc  = (acc && count_m != 65535) ? count_m + 1 : count_m;
    push(4, c + 2, 32'(count_m), "count_before_commit");
    push(4, c + 3, 32'(nc), "count_after_write");
    push(5, c + 3, 32'(err_m | !acc), "error_after_write");
    step();
    step();
    fa = a;
    fetch_exp(a, c + 3, "fetch_same_cycle_old");
    if (acc) begin
      mem_m[a[AW-1:0]] = d;
      val_m[a[AW-1:0]] = 1;
    end else begin
      err_m = 1;
    end
    count_m = nc;
    step();
    step();
    wr = 1'b0;
    repeat (3) step();
  endtask

  task automatic run_up();
    int c;
    step();
    c   = cyc;
    run = 1'b1;
    push(2, c + 2, 32'd1, "reset_before_start");
    push(2, c + 3, 32'd0, "reset_falls");
    push(3, c + 3, 32'd0, "running_in_start");
    push(3, c + 4, 32'd1, "running_rises");
    load_m = 0;
    repeat (4) step();
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) val_m[i] = 0;
    count_m = 0;
    err_m   = 0;
    load_m  = 1;
  endtask

  initial begin
    int c;
    logic [IW-1:0] d;
    model_reset();
    push(2, 1, 32'd1, "rst_reset");
    push(3, 1, 32'd0, "rst_running");
    push(4, 1, 32'd0, "rst_count");
    push(5, 1, 32'd0, "rst_error");
    push(0, 2, 32'hFFF, "rst_fdata");
    push(1, 2, 32'd0, "rst_fvalid");
    repeat (3) step();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      d = (i == 0) ? 12'h800 : (i == 11) ? 12'h306 : 12'($urandom);
      do_write(16'(i), d);
    end
    for (int i = 0; i <= 12; i++) do_fetch(16'(i));
    do_fetch(16'h0100);
    do_fetch(16'hFFFF);

    do_write(16'h0100, 12'h123);
    do_write(16'd5, 12'($urandom));
    do_fetch(16'd5);

    for (int i = 0; i < 10; i++) do_write(16'($urandom_range(0, 299)), 12'($urandom));
    for (int i = 0; i < 20; i++) do_fetch(16'($urandom_range(0, 320)));

    run_up();
    do_write(16'd3, 12'($urandom));
    do_fetch(16'd3);

    step();
    c    = cyc;
    halt = 1'b1;
    push(3, c + 1, 32'd0, "halt_stops_running");
    push(2, c + 1, 32'd0, "halt_reset_low");
    push(3, c + 3, 32'd0, "halted_no_restart");
    push(3, c + 5, 32'd0, "halted_no_restart_late");
    push(2, c + 5, 32'd0, "halted_reset_low");
    step();
    step();
    halt = 1'b0;
    repeat (4) step();

    c   = cyc;
    run = 1'b0;
    push(2, c + 2, 32'd0, "halted_reset_before_sync");
    push(2, c + 3, 32'd1, "halted_to_load_reset");
    push(3, c + 3, 32'd0, "halted_to_load_running");
    repeat (3) step();
    load_m = 1;
    do_write(16'd20, 12'($urandom));
    do_fetch(16'd20);

    run_up();
    step();
    c   = cyc;
    run = 1'b0;
    push(3, c + 2, 32'd1, "run_before_abort");
    step();
    step();
    halt = 1'b1;
    push(2, c + 3, 32'd1, "abort_wins_reset");
    push(3, c + 3, 32'd0, "abort_wins_running");
    push(2, c + 5, 32'd1, "abort_stays_load");
    step();
    halt = 1'b0;
    repeat (3) step();
    load_m = 1;

    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) do_write(16'(i), 12'($urandom));
    do_write(16'h01FF, 12'($urandom));
    run_up();
    step();
    fa = 16'd0;
    fetch_exp(16'd0, cyc + 1, "prereset_fetch");
    push(3, cyc + 1, 32'd1, "prereset_running");
    push(4, cyc + 1, 32'd7, "prereset_count");
    step();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    push(3, cyc, 32'd0, "async_rst_running");
    push(2, cyc, 32'd1, "async_rst_reset");
    push(4, cyc, 32'd0, "async_rst_count");
    push(5, cyc, 32'd0, "async_rst_error");
    push(1, cyc, 32'd0, "async_rst_fvalid");
    push(0, cyc, 32'hFFF, "async_rst_fdata");
    step();
    run = 1'b0;
    step();
    rst_n = 1'b1;
    do_fetch(16'd0);
    do_fetch(16'd6);

    repeat (4) step();
    if (q.size() != 0) begin
      $display("FAIL pending: %0d expectations never checked", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
